// File: rtl/text_term_ctrl.sv
// Character-stream terminal controller: accepts bytes, tracks a cursor, interprets CR/LF/BS/FF
// and issues single-cell {bg,fg,ascii} writes. Optional per-line auto-clear: TEXT_TERM_AUTOCLR_EN.
module text_term_ctrl #(
    parameter int          GRID_ROW     = 5,
    parameter int          GRID_COL     = 10,
    parameter int          ASCII_WIDTH  = 8,
    parameter int          BUFFER_WIDTH = 16,
    parameter logic [3:0]  DEF_FG       = 4'hF,
    parameter logic [3:0]  DEF_BG       = 4'h0,
    localparam int         CW = (GRID_COL > 1) ? $clog2(GRID_COL) : 1,
    localparam int         RW = (GRID_ROW > 1) ? $clog2(GRID_ROW) : 1
) (
    input  logic                    clk_pix,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ASCII_WIDTH-1:0]  in_ascii,
    input  logic [3:0]              fg_idx,
    input  logic [3:0]              bg_idx,
    output logic                    wr_en,
    output logic [CW-1:0]           wr_col,
    output logic [RW-1:0]           wr_row,
    output logic [BUFFER_WIDTH-1:0] wr_data,
    output logic [CW-1:0]           cur_col,
    output logic [RW-1:0]           cur_row,
    output logic                    busy
);

    localparam logic [CW-1:0]          COL_MAX = CW'(GRID_COL - 1);
    localparam logic [RW-1:0]          ROW_MAX = RW'(GRID_ROW - 1);
    localparam logic [ASCII_WIDTH-1:0] SP      = ASCII_WIDTH'(8'h20);

`ifdef TEXT_TERM_AUTOCLR_EN
    typedef enum logic [1:0] {IDLE, WRITE, CLEAR, CLRLINE} state_t;
`else
    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
`endif

    state_t                  state, next_state;
    logic                    accept;
    logic                    lat_ff;
    logic [3:0]              clr_fg, clr_bg;
    logic [CW-1:0]           clr_col;
    logic [RW-1:0]           clr_row;
    logic                    sweep;
    logic                    act_wr;
    logic [CW-1:0]           nxt_col;
    logic [RW-1:0]           nxt_row;
    logic [RW-1:0]           row_inc;
    logic [ASCII_WIDTH-1:0]  act_char;
    logic                    row_chg;
`ifdef TEXT_TERM_AUTOCLR_EN
    logic                    lat_row_chg;
`endif

    assign accept = in_valid & in_ready;

    // Decode the incoming byte against the current cursor; the result is committed on accept.
    always_comb begin
        act_wr   = 1'b0;
        act_char = in_ascii;
        nxt_col  = cur_col;
        nxt_row  = cur_row;
        row_chg  = 1'b0;
        row_inc  = (cur_row == ROW_MAX) ? '0 : cur_row + 1'b1;
        case (in_ascii)
            ASCII_WIDTH'(8'h0D): nxt_col = '0;
            ASCII_WIDTH'(8'h0A): begin
                nxt_row = row_inc;
                row_chg = 1'b1;
            end
            ASCII_WIDTH'(8'h08): begin
                act_char = SP;
                if (cur_col != '0) begin
                    nxt_col = cur_col - 1'b1;
                    act_wr  = 1'b1;
                end else if (cur_row != '0) begin
                    nxt_col = COL_MAX;
                    nxt_row = cur_row - 1'b1;
                    act_wr  = 1'b1;
                end
            end
            ASCII_WIDTH'(8'h0C): begin
                nxt_col = '0;
                nxt_row = '0;
            end
            default: begin
                if (in_ascii >= ASCII_WIDTH'(8'h20) && in_ascii <= ASCII_WIDTH'(8'h7E)) begin
                    act_wr = 1'b1;
                    if (cur_col == COL_MAX) begin
                        nxt_col = '0;
                        nxt_row = row_inc;
                        row_chg = 1'b1;
                    end else begin
                        nxt_col = cur_col + 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        next_state = state;
        sweep      = 1'b0;
        case (state)
            IDLE:  if (accept) next_state = WRITE;
            WRITE: begin
                if (lat_ff) next_state = CLEAR;
`ifdef TEXT_TERM_AUTOCLR_EN
                else if (lat_row_chg) next_state = CLRLINE;
`endif
                else next_state = IDLE;
            end
            CLEAR: begin
                sweep = 1'b1;
                if (clr_row == ROW_MAX && clr_col == COL_MAX) next_state = IDLE;
            end
`ifdef TEXT_TERM_AUTOCLR_EN
            CLRLINE: begin
                sweep = 1'b1;
                if (clr_col == COL_MAX) next_state = IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            state    <= CLEAR;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            wr_en    <= 1'b0;
            wr_col   <= '0;
            wr_row   <= '0;
            wr_data  <= '0;
            cur_col  <= '0;
            cur_row  <= '0;
            clr_col  <= '0;
            clr_row  <= '0;
            clr_fg   <= DEF_FG;
            clr_bg   <= DEF_BG;
            lat_ff   <= 1'b0;
`ifdef TEXT_TERM_AUTOCLR_EN
            lat_row_chg <= 1'b0;
`endif
        end else begin
            state    <= next_state;
            in_ready <= (next_state == IDLE);
            busy     <= (next_state != IDLE) && (next_state != WRITE);
            wr_en    <= 1'b0;
            if (state == IDLE && accept) begin
                lat_ff  <= (in_ascii == ASCII_WIDTH'(8'h0C));
                clr_fg  <= fg_idx;
                clr_bg  <= bg_idx;
                cur_col <= nxt_col;
                cur_row <= nxt_row;
`ifdef TEXT_TERM_AUTOCLR_EN
                lat_row_chg <= row_chg;
`endif
                if (act_wr) begin
                    wr_en   <= 1'b1;
                    wr_col  <= nxt_col;
                    wr_row  <= nxt_row;
                    wr_data <= BUFFER_WIDTH'({bg_idx, fg_idx, act_char});
                end
                // A printable write lands at the old cursor, not the advanced one.
                if (act_char != SP || in_ascii == SP) begin
                    wr_col <= act_wr ? cur_col : wr_col;
                    wr_row <= act_wr ? cur_row : wr_row;
                end
            end
            if (state == WRITE) begin
                clr_col <= '0;
                clr_row <= lat_ff ? '0 : cur_row;
            end
            if (sweep) begin
                wr_en   <= 1'b1;
                wr_col  <= clr_col;
                wr_row  <= clr_row;
                wr_data <= BUFFER_WIDTH'({clr_bg, clr_fg, SP});
                if (clr_col == COL_MAX) begin
                    clr_col <= '0;
                    if (state == CLEAR) clr_row <= clr_row + 1'b1;
                end else begin
                    clr_col <= clr_col + 1'b1;
                end
            end
        end
    end

    logic unused_ok;
    assign unused_ok = row_chg;

endmodule

// File: tb/tb_text_term_ctrl.sv
// Bench for text_term_ctrl: directed steps plus random byte stream checked against a screen-level model.
module tb_text_term_ctrl;

    logic        clk_pix = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_ascii = 8'h00;
    logic [3:0]  fg_idx = 4'h0;
    logic [3:0]  bg_idx = 4'h0;
    logic        wr_en;
    logic [3:0]  wr_col;
    logic [2:0]  wr_row;
    logic [15:0] wr_data;
    logic [3:0]  cur_col;
    logic [2:0]  cur_row;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int mr = 0;
    int mc = 0;
    logic [22:0] exp_q[$];
    logic [22:0] got_q[$];

    text_term_ctrl dut (
        .clk_pix(clk_pix), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ascii(in_ascii), .fg_idx(fg_idx), .bg_idx(bg_idx), .wr_en(wr_en),
        .wr_col(wr_col), .wr_row(wr_row), .wr_data(wr_data), .cur_col(cur_col),
        .cur_row(cur_row), .busy(busy)
    );

    always #5 clk_pix = ~clk_pix;

    always @(negedge clk_pix) begin
        if (wr_en === 1'b1) got_q.push_back({wr_row, wr_col, wr_data});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_cell(input int r, input int c, input logic [15:0] d);
        exp_q.push_back({r[2:0], c[3:0], d});
    endtask

    task automatic model_row_clear(input int r, input int fg, input int bg);
`ifdef TEXT_TERM_AUTOCLR_EN
        for (int c = 0; c < 10; c++) push_cell(r, c, {bg[3:0], fg[3:0], 8'h20});
`endif
    endtask

    task automatic model_byte(input int a, input int fg, input int bg);
        logic [7:0] ch;
        ch = a[7:0];
        if (a >= 32 && a <= 126) begin
            push_cell(mr, mc, {bg[3:0], fg[3:0], ch});
            mc++;
            if (mc == 10) begin
                mc = 0;
                mr = (mr + 1) % 5;
                model_row_clear(mr, fg, bg);
            end
        end else if (a == 13) begin
            mc = 0;
        end else if (a == 10) begin
            mr = (mr + 1) % 5;
            model_row_clear(mr, fg, bg);
        end else if (a == 8) begin
            if (mc > 0 || mr > 0) begin
                if (mc > 0) mc--;
                else begin
                    mc = 9;
                    mr--;
                end
                push_cell(mr, mc, {bg[3:0], fg[3:0], 8'h20});
            end
        end else if (a == 12) begin
            for (int i = 0; i < 50; i++) push_cell(i / 10, i % 10, {bg[3:0], fg[3:0], 8'h20});
            mr = 0;
            mc = 0;
        end
    endtask

    task automatic send(input int a, input int fg, input int bg);
        int n;
        @(negedge clk_pix);
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk_pix);
            n++;
        end
        if (n >= 200) chk("ready_timeout", in_ready, 1);
        in_valid = 1'b1;
        in_ascii = a[7:0];
        fg_idx   = fg[3:0];
        bg_idx   = bg[3:0];
        @(posedge clk_pix);
        #1;
        in_valid = 1'b0;
        in_ascii = 8'($urandom);
        fg_idx   = 4'($urandom);
        bg_idx   = 4'($urandom);
        model_byte(a, fg, bg);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(in_ready === 1'b1 && busy === 1'b0) && n < 200) begin
            @(posedge clk_pix);
            #1;
            n++;
        end
        if (n >= 200) chk("idle_timeout", {in_ready, busy}, 2'b10);
        @(posedge clk_pix);
        #1;
    endtask

    task automatic settle(input string tag);
        wait_idle();
        chk({tag, "_cur_col"}, cur_col, mc);
        chk({tag, "_cur_row"}, cur_row, mr);
        chk({tag, "_wr_cnt"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) chk({tag, "_wr"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int r, a, n_wr;
        // reset and power-on sweep
        repeat (2) @(posedge clk_pix);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_cursor", {cur_row, cur_col}, 0);
        rst = 1'b0;
        model_byte(12, 15, 0);
        settle("sweep");

        // single printable with handshake timing
        send(8'h41, 2, 1);
        chk("a_wr_en", wr_en, 1);
        chk("a_wr_data", wr_data, 16'h1241);
        chk("a_wr_pos", {wr_row, wr_col}, 0);
        chk("a_in_ready_low", in_ready, 0);
        chk("a_cur_col", cur_col, 1);
        @(posedge clk_pix);
        #1;
        chk("a_in_ready_back", in_ready, 1);
        settle("a");

        // row fill and full-grid wrap
        send(13, 0, 0);
        settle("cr");
        for (int i = 0; i < 10; i++) send(8'h58, 7, 0);
        settle("row0");
        for (int i = 0; i < 40; i++) send(8'h58, i % 16, 3);
        settle("wrap");

        // backspace across row boundary and at origin
        send(10, 1, 1);
        send(10, 1, 1);
        settle("lf2");
        send(8, 6, 2);
        settle("bs_row");
        send(12, 15, 0);
        settle("ff");
        send(8, 6, 2);
        settle("bs_origin");

        // CR/LF only move, ignored codes
        send(8'h41, 4, 0);
        send(8'h42, 4, 0);
        send(13, 4, 0);
        send(10, 4, 0);
        settle("ab_crlf");
        send(8'h07, 4, 0);
        send(8'hFF, 4, 0);
        send(8'h7F, 4, 0);
        settle("ignored");

`ifdef TEXT_TERM_AUTOCLR_EN
        send(8'h41, 5, 1);
        send(8'h42, 5, 1);
        send(8'h43, 5, 1);
        send(8'h44, 5, 1);
        settle("pre_lf");
        send(10, 9, 2);
        settle("autoclr_lf");
`endif

        // random byte stream
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70) a = $urandom_range(32, 126);
            else if (r < 77) a = 13;
            else if (r < 84) a = 10;
            else if (r < 92) a = 8;
            else if (r < 94) a = 12;
            else if (r < 97) a = $urandom_range(127, 255);
            else a = $urandom_range(0, 7);
            send(a, $urandom_range(0, 15), $urandom_range(0, 15));
            settle("rand");
        end

        // reset in the middle of a form-feed sweep
        send(12, 3, 5);
        n_wr = 0;
        for (int k = 0; k < 200 && n_wr < 20; k++) begin
            @(posedge clk_pix);
            #1;
            if (wr_en === 1'b1) n_wr++;
        end
        chk("ff_partial_cnt", n_wr, 20);
        rst = 1'b1;
        @(posedge clk_pix);
        #1;
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_cursor", {cur_row, cur_col}, 0);
        rst = 1'b0;
        while (exp_q.size() > 20) void'(exp_q.pop_back());
        mr = 0;
        mc = 0;
        for (int i = 0; i < 50; i++) push_cell(i / 10, i % 10, 16'h0F20);
        settle("rst_sweep");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
